inv_nr_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one inv_nr reciprocal engine between NREQ requesters.

---
 rtl/inv_nr_arb_if.sv | 29 ++
 rtl/inv_nr_arb.sv | 145 ++++++++++++++
 tb/tb_inv_nr_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_nr_arb_if.sv
// Requester and engine-side signal bundle for inv_nr_arb.
// master = clients plus the inv_nr engine; slave = the arbiter itself.
interface inv_nr_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int RW   = 24
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rsp_v;
   logic [RW-1:0]      rsp_data;
   logic               rsp_err;
   logic               busy;
   logic [DW-1:0]      eng_in;
   logic               eng_start;
   logic [RW-1:0]      eng_op;
   logic               eng_op_v;

   modport master (
      output req, req_data, eng_op, eng_op_v,
      input  gnt, rsp_v, rsp_data, rsp_err, busy, eng_in, eng_start
   );

   modport slave (
      input  req, req_data, eng_op, eng_op_v,
      output gnt, rsp_v, rsp_data, rsp_err, busy, eng_in, eng_start
   );
endinterface

// File: rtl/inv_nr_arb.sv
// Round-robin sequencer sharing one inv_nr reciprocal engine between NREQ clients.
// Optional engine timeout enabled by defining INV_ARB_TIMEOUT_EN.
module inv_nr_arb #(
   parameter int NREQ    = 4,
   parameter int DW      = 16,
   parameter int RW      = 24,
   parameter int TMO_CYC = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   inv_nr_arb_if.slave  bus
);
   localparam int PW = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   if (NREQ < 2 || NREQ > 8 || TMO_CYC < 1) begin : g_bad_param
      $error("inv_nr_arb: unsupported NREQ or TMO_CYC");
   end

   typedef enum logic [1:0] {IDLE, WAIT, ZERO} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d, win;
   logic            win_v;
   logic [DW-1:0]   win_data;
   logic [NREQ-1:0] gnt_q, gnt_d, rsp_v_q, rsp_v_d;
   logic [RW-1:0]   rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic [DW-1:0]   eng_in_q, eng_in_d;
   logic            eng_start_q, eng_start_d;
   logic            tmo_hit;

   // First requester at or after ptr, wrapping; the just-served one sits last.
   always_comb begin : p_arb
      int idx;
      idx   = 0;
      win_v = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_v && bus.req[idx]) begin
            win_v = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   assign win_data = bus.req_data[win*DW +: DW];

`ifdef INV_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;

   // cnt_q counts completed WAIT cycles; zero on the first WAIT cycle.
   assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
   assign tmo_hit = (cnt_q == CW'(TMO_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      own_d       = own_q;
      gnt_d       = '0;
      rsp_v_d     = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = 1'b0;
      eng_in_d    = eng_in_q;
      eng_start_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_v) begin
               gnt_d = ONE << win;
               own_d = win;
               ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
               if (win_data == '0) begin
                  state_d = ZERO;
               end else begin
                  eng_in_d    = win_data;
                  eng_start_d = 1'b1;
                  state_d     = WAIT;
               end
            end
         end
         WAIT: begin
            // A result landing on the timeout cycle still counts as a normal answer.
            if (bus.eng_op_v) begin
               rsp_data_d = bus.eng_op;
               rsp_v_d    = ONE << own_q;
               state_d    = IDLE;
            end else if (tmo_hit) begin
               rsp_data_d = '1;
               rsp_err_d  = 1'b1;
               rsp_v_d    = ONE << own_q;
               state_d    = IDLE;
            end
         end
         ZERO: begin
            rsp_data_d = '1;
            rsp_v_d    = ONE << own_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         own_q       <= '0;
         gnt_q       <= '0;
         rsp_v_q     <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         eng_in_q    <= '0;
         eng_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         own_q       <= own_d;
         gnt_q       <= gnt_d;
         rsp_v_q     <= rsp_v_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         eng_in_q    <= eng_in_d;
         eng_start_q <= eng_start_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_v     = rsp_v_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.eng_in    = eng_in_q;
   assign bus.eng_start = eng_start_q;
endmodule

// File: tb/tb_inv_nr_arb.sv
// Directed bench for inv_nr_arb with an 8-cycle inv_nr stand-in
// (op = {8'h0,in} ^ 24'hA5A5A5).
module tb_inv_nr_arb;
   localparam int NREQ = 4;
   localparam int DW   = 16;
   localparam int RW   = 24;

   logic clk;
   logic rst_n;

   inv_nr_arb_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

   inv_nr_arb #(.NREQ(NREQ), .DW(DW), .RW(RW), .TMO_CYC(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // engine model state
   int            eng_cnt    = 0;
   logic [RW-1:0] eng_res    = '0;
   logic [DW-1:0] eng_lat    = '0;
   int            n_start    = 0;
   int            eng_in_bad = 0;
   int            stray_seen = 0;
   logic          eng_en;
   int            stray_req;

   logic [NREQ-1:0] gnt_log[$];
   logic [NREQ-1:0] rsp_who[$];
   logic [RW-1:0]   rsp_dat[$];
   int              gnt_cyc[$];
   int              rsp_cyc[$];
   int              rsp_errs;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      logic [RW-1:0] exp_data;
      int            exp_lat;
      logic          exp_start;
   } vec_t;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.eng_op   = '0;
      bus.eng_op_v = 1'b0;
      forever begin
         @(posedge clk); #1;
         bus.eng_op_v = 1'b0;
         if (eng_cnt > 0) begin
            if (bus.busy && bus.eng_in !== eng_lat) eng_in_bad++;
            eng_cnt--;
            if (eng_cnt == 0 && eng_en) begin
               bus.eng_op_v = 1'b1;
               bus.eng_op   = eng_res;
            end
         end
         if (stray_req != stray_seen) begin
            stray_seen   = stray_req;
            bus.eng_op_v = 1'b1;
            bus.eng_op   = 24'h123456;
         end
         if (bus.eng_start) begin
            eng_cnt = 8;
            eng_lat = bus.eng_in;
            eng_res = {8'h00, bus.eng_in} ^ 24'hA5A5A5;
            n_start++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_missing(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: expected event never observed", nm);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_gnt"},       32'(bus.gnt),       32'h0);
      chk({tag, "_rsp_v"},     32'(bus.rsp_v),     32'h0);
      chk({tag, "_rsp_data"},  32'(bus.rsp_data),  32'h0);
      chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
      chk({tag, "_busy"},      32'(bus.busy),      32'h0);
      chk({tag, "_eng_in"},    32'(bus.eng_in),    32'h0);
      chk({tag, "_eng_start"}, 32'(bus.eng_start), 32'h0);
   endtask

   task automatic wait_gnt(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (bus.gnt == '0 && cyc < 10);
   endtask

   // Holds req=m, drops each bit as its grant shows, logs grants and responses.
   task automatic run_set(input logic [NREQ-1:0] m, input int budget);
      int cyc;
      int pend;
      gnt_log.delete(); rsp_who.delete(); rsp_dat.delete();
      gnt_cyc.delete(); rsp_cyc.delete();
      rsp_errs = 0;
      pend     = $countones(m);
      bus.req  = m;
      cyc      = 0;
      while (rsp_who.size() < pend && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (bus.gnt != '0) begin
            gnt_log.push_back(bus.gnt);
            gnt_cyc.push_back(cyc);
            bus.req = bus.req & ~bus.gnt;
         end
         if (bus.rsp_v != '0) begin
            rsp_who.push_back(bus.rsp_v);
            rsp_dat.push_back(bus.rsp_data);
            rsp_cyc.push_back(cyc);
            if (bus.rsp_err) rsp_errs++;
         end
      end
      bus.req = '0;
   endtask

   initial begin
      vec_t            tbl[5];
      logic [NREQ-1:0] fo[4];
      logic [RW-1:0]   fd[4];
      logic [RW-1:0]   old;
      int              cyc;
      int              seen;
      int              s0;

      tbl[0] = '{1, 16'h5E67, 24'hA5FBC2, 9, 1'b1};
      tbl[1] = '{2, 16'h0000, 24'hFFFFFF, 1, 1'b0};
      tbl[2] = '{0, 16'h0001, 24'hA5A5A4, 9, 1'b1};
      tbl[3] = '{3, 16'hFFFF, 24'hA55A5A, 9, 1'b1};
      tbl[4] = '{0, 16'h0000, 24'hFFFFFF, 1, 1'b0};

      rst_n        = 1'b0;
      bus.req      = '0;
      bus.req_data = '0;
      eng_en       = 1'b1;
      stray_req    = 0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fairness from ptr=0: orders 0,1,2,3 with back-to-back grants
      fo = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      fd = '{24'hA5B791, 24'hA50E68, 24'hFFFFFF, 24'hA525A4};
      bus.req_data = {16'h8001, 16'h0000, 16'hABCD, 16'h1234};
      s0 = n_start;
      run_set(4'b1111, 200);
      chk("fair_ngnt", 32'(gnt_log.size()), 32'd4);
      chk("fair_nrsp", 32'(rsp_who.size()), 32'd4);
      chk("fair_err", 32'(rsp_errs), 32'd0);
      for (int i = 0; i < 4; i++) begin
         if (i < gnt_log.size() && i < rsp_who.size()) begin
            chk($sformatf("fair_gnt%0d", i), 32'(gnt_log[i]), 32'(fo[i]));
            chk($sformatf("fair_who%0d", i), 32'(rsp_who[i]), 32'(fo[i]));
            chk($sformatf("fair_dat%0d", i), 32'(rsp_dat[i]), 32'(fd[i]));
            if (i < 3 && i + 1 < gnt_cyc.size())
               chk($sformatf("fair_b2b%0d", i), 32'(gnt_cyc[i+1]), 32'(rsp_cyc[i] + 1));
         end else begin
            fail_missing($sformatf("fair_evt%0d", i));
         end
      end
      @(posedge clk); #1;
      chk("fair_starts", 32'(n_start - s0), 32'd3);

      // single-request vectors
      for (int t = 0; t < 5; t++) begin
         logic [NREQ-1:0] m;
         m = 4'b0001 << tbl[t].idx;
         bus.req_data[tbl[t].idx*DW +: DW] = tbl[t].data;
         bus.req = m;
         wait_gnt(cyc);
         chk($sformatf("v%0d_gnt", t), 32'(bus.gnt), 32'(m));
         chk($sformatf("v%0d_gnt_lat", t), 32'(cyc), 32'd1);
         chk($sformatf("v%0d_eng_start", t), 32'(bus.eng_start), 32'(tbl[t].exp_start));
         if (tbl[t].exp_start)
            chk($sformatf("v%0d_eng_in", t), 32'(bus.eng_in), 32'(tbl[t].data));
         cyc = 0;
         while (bus.rsp_v == '0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus.req = '0;
         end
         chk($sformatf("v%0d_rsp_v", t), 32'(bus.rsp_v), 32'(m));
         chk($sformatf("v%0d_rsp_lat", t), 32'(cyc), 32'(tbl[t].exp_lat));
         chk($sformatf("v%0d_rsp_data", t), 32'(bus.rsp_data), 32'(tbl[t].exp_data));
         chk($sformatf("v%0d_rsp_err", t), 32'(bus.rsp_err), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_rsp_v_off", t), 32'(bus.rsp_v), 32'h0);
         chk($sformatf("v%0d_busy_off", t), 32'(bus.busy), 32'h0);
         chk($sformatf("v%0d_rsp_hold", t), 32'(bus.rsp_data), 32'(tbl[t].exp_data));
      end

      // stray engine valid while idle
      old = bus.rsp_data;
      stray_req++;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.rsp_v != '0) seen++;
      end
      chk("stray_rsp_v", 32'(seen), 32'd0);
      chk("stray_data", 32'(bus.rsp_data), 32'(old));
      chk("stray_busy", 32'(bus.busy), 32'h0);

      // reset three cycles into an engine operation
      bus.req_data = '0;
      bus.req_data[DW +: DW] = 16'h7777;
      bus.req = 4'b0010;
      wait_gnt(cyc);
      chk("mid_gnt", 32'(bus.gnt), 32'h2);
      chk("mid_start", 32'(bus.eng_start), 32'h1);
      bus.req = '0;
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_idle_outs("midrst");
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.rsp_v != '0) seen++;
      end
      chk("midrst_late_rsp", 32'(seen), 32'd0);
      bus.req_data[0 +: DW]    = 16'h0001;
      bus.req_data[2*DW +: DW] = 16'h0000;
      run_set(4'b0101, 100);
      if (gnt_log.size() == 2 && rsp_dat.size() == 2) begin
         chk("post_gnt0", 32'(gnt_log[0]), 32'h1);
         chk("post_gnt1", 32'(gnt_log[1]), 32'h4);
         chk("post_dat0", 32'(rsp_dat[0]), 32'hA5A5A4);
         chk("post_dat1", 32'(rsp_dat[1]), 32'hFFFFFF);
      end else begin
         fail_missing("post_reset_events");
      end

`ifdef INV_ARB_TIMEOUT_EN
      // silent engine: error response after 16 WAIT cycles
      @(posedge clk); #1;
      eng_en = 1'b0;
      bus.req_data[0 +: DW] = 16'h1234;
      bus.req = 4'b0001;
      wait_gnt(cyc);
      chk("tmo_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      cyc = 0;
      while (bus.rsp_v == '0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("tmo_lat", 32'(cyc), 32'd16);
      chk("tmo_rsp_v", 32'(bus.rsp_v), 32'h1);
      chk("tmo_err", 32'(bus.rsp_err), 32'h1);
      chk("tmo_data", 32'(bus.rsp_data), 32'hFFFFFF);
      @(posedge clk); #1;
      chk("tmo_busy", 32'(bus.busy), 32'h0);
      chk("tmo_err_off", 32'(bus.rsp_err), 32'h0);
      eng_en = 1'b1;
`endif

      repeat (12) @(posedge clk);
      #1;
      chk("eng_in_stable", 32'(eng_in_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
